// File: rtl/cla_seq_subtractor_pkg.sv
// ---------------------------------------------------------------------------
// cla_pkg: shared definitions for the nibble-serial CLA subtractor.
//   state_e      FSM states (IDLE, RUN, DONE)
//   SLICE_W      width of one carry-look-ahead slice (4 bits)
//   DEF_WIDTH    default operand width, DEF_NIB nibble passes for it
//   cnt_width()  nibble-counter width for a given pass count (min 1 bit)
//   NIB_CNT_W    nibble-counter width for the default operand width
// ---------------------------------------------------------------------------
package cla_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int SLICE_W   = 4;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_NIB   = DEF_WIDTH / SLICE_W;

  // A single-pass configuration still needs a one-bit counter.
  function automatic int cnt_width(input int nib);
    return (nib > 1) ? $clog2(nib) : 1;
  endfunction

  localparam int NIB_CNT_W = cnt_width(DEF_NIB);

endpackage

// File: rtl/cla_seq_subtractor_if.sv
// ---------------------------------------------------------------------------
// cla_seq_subtractor_if: operand and result handshakes of the subtractor.
//   in_valid/in_ready  operand handshake, carries a, b, bin
//   out_valid/out_ready result handshake, carries diff, bout, zero, ovf
//   master modport: producer/consumer side; slave modport: the subtractor.
// ---------------------------------------------------------------------------
interface cla_seq_subtractor_if #(
  parameter int WIDTH = 16
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             zero;
  logic             ovf;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout, zero, ovf
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout, zero, ovf
  );

endinterface

// File: rtl/cla_seq_subtractor_slice.sv
// ---------------------------------------------------------------------------
// cla_sub_slice4: combinational 4-bit carry-look-ahead slice used for
// subtraction as a + nb + cin, where nb is the already inverted subtrahend
// nibble and cin is the running carry (the inverted borrow).
//   a    in  4  minuend nibble
//   nb   in  4  inverted subtrahend nibble
//   cin  in  1  carry in
//   sum  out 4  result nibble
//   cout out 1  group carry out
// ---------------------------------------------------------------------------
module cla_sub_slice4 (
  input  logic [3:0] a,
  input  logic [3:0] nb,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [3:0] p_s;
  logic [3:0] g_s;
  logic [3:0] c_s;
  logic       gg_s;
  logic       gp_s;

  assign p_s = a ^ nb;
  assign g_s = a & nb;

  // Every internal carry is a flat sum of products of p/g and cin.
  assign c_s[0] = cin;
  assign c_s[1] = g_s[0] | (p_s[0] & cin);
  assign c_s[2] = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & cin);
  assign c_s[3] = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
                | (p_s[2] & p_s[1] & p_s[0] & cin);

  // Group generate/propagate give the slice carry-out without rippling.
  assign gg_s = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
              | (p_s[3] & p_s[2] & p_s[1] & g_s[0]);
  assign gp_s = &p_s;

  assign sum  = p_s ^ c_s;
  assign cout = gg_s | (gp_s & cin);

endmodule

// File: rtl/cla_seq_subtractor.sv
// ---------------------------------------------------------------------------
// cla_seq_subtractor: multi-cycle subtractor, diff = a - b - bin, one nibble
// per clock through a single 4-bit CLA slice.
//   clk, rst   clock and synchronous active-high reset
//   bus        slave side of cla_seq_subtractor_if:
//              in_valid/in_ready + a, b, bin     operands
//              out_valid/out_ready + diff, bout, zero, ovf  result
// Accept at edge t0 -> out_valid after edge t0+NIB; one operation in flight.
// ---------------------------------------------------------------------------
module cla_seq_subtractor
  import cla_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  cla_seq_subtractor_if.slave bus
);

  localparam int NIB = WIDTH / SLICE_W;
  localparam int CW  = (WIDTH == DEF_WIDTH) ? NIB_CNT_W : cnt_width(NIB);
  localparam logic [CW-1:0] LAST_NIB = CW'(NIB - 1);

  state_e           state_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] nb_r;
  logic [WIDTH-1:0] res_r;
  logic             carry_r;
  logic [WIDTH-1:0] diff_r;
  logic             bout_r;
  logic             zero_r;
  logic             ovf_r;
  logic             out_valid_r;
  logic             in_ready_r;

  logic [SLICE_W-1:0] a_nib_s;
  logic [SLICE_W-1:0] nb_nib_s;
  logic [SLICE_W-1:0] sum_s;
  logic               cout_s;
  logic [WIDTH-1:0]   res_next_s;
  logic [CW+1:0]      shamt_s;

  // Bit offset of the current nibble (counter * 4).
  assign shamt_s  = {cnt_r, 2'b00};
  assign a_nib_s  = SLICE_W'(a_r >> shamt_s);
  assign nb_nib_s = SLICE_W'(nb_r >> shamt_s);

  cla_sub_slice4 u_slice (
    .a    (a_nib_s),
    .nb   (nb_nib_s),
    .cin  (carry_r),
    .sum  (sum_s),
    .cout (cout_s)
  );

  // The work register is cleared at accept, so nibbles can be OR-ed in.
  assign res_next_s = res_r | (WIDTH'(sum_s) << shamt_s);

  // FSM, operand/work registers and result/flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      cnt_r       <= '0;
      a_r         <= '0;
      nb_r        <= '0;
      res_r       <= '0;
      carry_r     <= 1'b0;
      diff_r      <= '0;
      bout_r      <= 1'b0;
      zero_r      <= 1'b0;
      ovf_r       <= 1'b0;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.in_valid && in_ready_r) begin
            a_r        <= bus.a;
            nb_r       <= ~bus.b;
            carry_r    <= ~bus.bin;
            cnt_r      <= '0;
            res_r      <= '0;
            in_ready_r <= 1'b0;
            state_r    <= RUN;
          end
        end
        RUN: begin
          res_r   <= res_next_s;
          carry_r <= cout_s;
          cnt_r   <= cnt_r + CW'(1);
          if (cnt_r == LAST_NIB) begin
            // All flags are taken from the completed result in one edge.
            diff_r      <= res_next_s;
            bout_r      <= ~cout_s;
            zero_r      <= (res_next_s == '0);
            // a and b differ in sign when a's MSB equals inverted b's MSB.
            ovf_r       <= (a_r[WIDTH-1] == nb_r[WIDTH-1]) &&
                           (res_next_s[WIDTH-1] != a_r[WIDTH-1]);
            out_valid_r <= 1'b1;
            cnt_r       <= '0;
            state_r     <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= IDLE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  // in_ready is forced low for as long as reset is held.
  assign bus.in_ready  = in_ready_r & ~rst;
  assign bus.out_valid = out_valid_r;
  assign bus.diff      = diff_r;
  assign bus.bout      = bout_r;
  assign bus.zero      = zero_r;
  assign bus.ovf       = ovf_r;

endmodule

// File: tb/tb_cla_seq_subtractor.sv
// ---------------------------------------------------------------------------
// tb_cla_seq_subtractor: scoreboard bench for cla_seq_subtractor (WIDTH=16).
// Stimulus pushes the arithmetic expectation of every accepted operation;
// a monitor pops and compares on each result handshake and checks latency.
// ---------------------------------------------------------------------------
module tb_cla_seq_subtractor;

  typedef struct {
    logic [15:0] diff;
    logic        bout;
    logic        zero;
    logic        ovf;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb[$];
  int   rdy_mode  = 0;   // 0: always ready, 1: random, 2: forced value
  logic rdy_force = 1'b1;

  cla_seq_subtractor_if #(.WIDTH(16)) bus ();

  cla_seq_subtractor #(.WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer arithmetic, unsigned for borrow, signed for overflow.
  function automatic exp_t model(input logic [15:0] ta, input logic [15:0] tb_, input logic tbin);
    exp_t        e;
    logic [16:0] full;
    int          sd;
    full   = {1'b0, ta} - {1'b0, tb_} - {16'd0, tbin};
    sd     = int'($signed(ta)) - int'($signed(tb_)) - int'(tbin);
    e.diff = full[15:0];
    e.bout = full[16];
    e.zero = (full[15:0] == 16'd0);
    e.ovf  = (sd > 32767) || (sd < -32768);
    e.acc  = 0;
    return e;
  endfunction

  task automatic send(input logic [15:0] ta, input logic [15:0] tb_, input logic tbin);
    exp_t e;
    int   n;
    bus.a = ta;
    bus.b = tb_;
    bus.bin = tbin;
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.in_ready) begin
      chk("send_ready_timeout", 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1'b0;
    end else begin
      @(posedge clk); #1;
      e = model(ta, tb_, tbin);
      e.acc = cyc;
      sb.push_back(e);
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain", 32'(sb.size()), 32'd0);
  endtask

  // out_ready driver; applied 2 time units after each rising edge.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk); #2;
      case (rdy_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = ($urandom_range(0, 3) != 0);
        default: bus.out_ready = rdy_force;
      endcase
    end
  end

  // Monitor: latency on each out_valid rise, scoreboard compare on handshake.
  initial begin
    exp_t e;
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev = 1'b0;
      end else begin
        if (bus.out_valid) begin
          if (sb.size() == 0) begin
            chk("unexpected_out_valid", 32'(bus.out_valid), 32'd0);
          end else begin
            if (!prev) chk("latency", 32'(cyc - sb[0].acc), 32'd4);
            if (bus.out_ready) begin
              e = sb.pop_front();
              chk("diff", 32'(bus.diff), 32'(e.diff));
              chk("bout", 32'(bus.bout), 32'(e.bout));
              chk("zero", 32'(bus.zero), 32'(e.zero));
              chk("ovf",  32'(bus.ovf),  32'(e.ovf));
            end
          end
        end
        prev = bus.out_valid;
      end
    end
  end

  initial begin
    exp_t x;
    int   n;
    logic [15:0] ra, rb;
    bus.in_valid = 1'b0;
    bus.a = 16'd0;
    bus.b = 16'd0;
    bus.bin = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_diff", 32'(bus.diff), 32'd0);
    chk("rst_flags", {29'd0, bus.bout, bus.zero, bus.ovf}, 32'd0);
    rst = 1'b0;
    #1;
    chk("idle_in_ready", 32'(bus.in_ready), 32'd1);

    // Directed cases.
    send(16'h0005, 16'h0003, 1'b0);
    send(16'h1000, 16'h0001, 1'b0);
    send(16'h0000, 16'h0001, 1'b0);
    send(16'h8000, 16'h0001, 1'b0);
    send(16'h1234, 16'h1233, 1'b1);
    send(16'h7FFF, 16'hFFFF, 1'b0);
    send(16'hFFFF, 16'hFFFF, 1'b1);
    wait_drain();

    // Back-pressure in DONE with new operands waiting.
    rdy_mode = 2;
    rdy_force = 1'b0;
    x = model(16'h4321, 16'h0123, 1'b0);
    send(16'h4321, 16'h0123, 1'b0);
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("hold_valid_seen", 32'(bus.out_valid), 32'd1);
    bus.a = 16'h0F0F;
    bus.b = 16'h0101;
    bus.bin = 1'b1;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("hold_out_valid", 32'(bus.out_valid), 32'd1);
      chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
      chk("hold_diff", 32'(bus.diff), 32'(x.diff));
    end
    rdy_force = 1'b1;
    @(posedge clk); #1;
    rdy_force = 1'b0;
    chk("ready_after_pulse", 32'(bus.in_ready), 32'd1);
    send(16'h0F0F, 16'h0101, 1'b1);
    rdy_mode = 0;
    wait_drain();

    // Reset during RUN after two nibbles.
    send(16'hAAAA, 16'h5555, 1'b0);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    void'(sb.pop_back());
    @(posedge clk); #1;
    chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
    chk("abort_in_ready_rst", 32'(bus.in_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
    chk("abort_diff", 32'(bus.diff), 32'd0);
    send(16'h00FF, 16'h0001, 1'b0);
    wait_drain();

    // Randomized traffic with random back-pressure.
    rdy_mode = 1;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 4))
        0:       ra = 16'h8000;
        1:       ra = 16'h7FFF;
        default: ra = 16'($urandom);
      endcase
      case ($urandom_range(0, 4))
        0:       rb = 16'hFFFF;
        1:       rb = ra;
        default: rb = 16'($urandom);
      endcase
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      send(ra, rb, 1'($urandom_range(0, 1)));
    end
    rdy_mode = 0;
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
